// File: rtl/mem_wb_pipe_if.sv
// MEM/WB stage bus: the accept side (in_*) from the data-memory stage and the
// retire side (out_*) toward the register-file write port.
interface mem_wb_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              in_reg_write;
    logic [1:0]        in_wb_sel;
    logic [REG_AW-1:0] in_rd;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_mem_data;
    logic [DATA_W-1:0] in_pc_plus4;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic              out_reg_write;
    logic [REG_AW-1:0] out_rd;
    logic [DATA_W-1:0] out_wb_data;

    modport slave (
        input  in_valid, in_reg_write, in_wb_sel, in_rd,
        input  in_alu_result, in_mem_data, in_pc_plus4,
        input  flush, out_ready,
        output in_ready, out_valid, out_reg_write, out_rd, out_wb_data
    );

    modport master (
        output in_valid, in_reg_write, in_wb_sel, in_rd,
        output in_alu_result, in_mem_data, in_pc_plus4,
        output flush, out_ready,
        input  in_ready, out_valid, out_reg_write, out_rd, out_wb_data
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: write-back mux applied at capture, optional two-entry
// skid buffer, flush, and a saturating back-pressure stall counter.
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    mem_wb_pipe_if.slave     bus,
    output logic [CNT_W-1:0] stall_cnt
);
    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; valid never depends on ready, and held entries leave in order.
    typedef struct packed {
        logic              rw;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           new_e;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             in_ready;
    logic             accept;
    logic             retire;

    always_comb begin
        new_e.rw = bus.in_reg_write | (bus.in_wb_sel == 2'b10);
        new_e.rd = bus.in_rd;
        case (bus.in_wb_sel)
            2'b01:   new_e.data = bus.in_mem_data;
            2'b10:   new_e.data = bus.in_pc_plus4;
            default: new_e.data = bus.in_alu_result;
        endcase
    end

    assign accept = bus.in_valid & in_ready;
    assign retire = main_v_q & bus.out_ready;

    always_comb begin
        main_v_d    = main_v_q;
        main_d      = main_q;
        skid_v_d    = skid_v_q;
        skid_d      = skid_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (retire || !main_v_q) begin
            // Main slot is free this edge: oldest held entry moves up first.
            if (skid_v_q) begin
                main_v_d = 1'b1;
                main_d   = skid_q;
                skid_v_d = accept;
                if (accept) skid_d = new_e;
            end else begin
                main_v_d = accept;
                if (accept) main_d = new_e;
            end
        end else if (accept) begin
            skid_v_d = 1'b1;
            skid_d   = new_e;
        end
        if (main_v_q && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) in_ready_q <= 1'b1;
                else     in_ready_q <= !skid_v_d;
            end
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            // Without a skid slot the only space is the one retiring this edge.
            assign in_ready = !main_v_q | bus.out_ready;
        end
    endgenerate

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = main_v_q;
    assign bus.out_rd        = main_q.rd;
    assign bus.out_wb_data   = main_q.data;
    assign bus.out_reg_write = main_v_q & main_q.rw & (main_q.rd != '0);
    assign stall_cnt         = stall_cnt_q;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: a skid build (16-bit counter) and a single-register
// build (4-bit counter) share one stimulus stream, each checked against a FIFO model.
module tb_mem_wb_pipe;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int EW = 1 + AW + DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_wb_pipe_if #(.DATA_W(DW), .REG_AW(AW)) bus0 ();
    mem_wb_pipe_if #(.DATA_W(DW), .REG_AW(AW)) bus1 ();
    logic [15:0] stall0;
    logic [3:0]  stall1;

    mem_wb_pipe #(.DATA_W(DW), .REG_AW(AW), .SKID(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .stall_cnt(stall0));
    mem_wb_pipe #(.DATA_W(DW), .REG_AW(AW), .SKID(0), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .stall_cnt(stall1));

    logic          c_valid = 1'b0, c_rw = 1'b0, c_flush = 1'b0, c_ordy = 1'b0;
    logic [1:0]    c_sel = '0;
    logic [AW-1:0] c_rd = '0;
    logic [DW-1:0] c_alu = '0, c_mem = '0, c_pc = '0;

    assign bus0.in_valid = c_valid;  assign bus1.in_valid = c_valid;
    assign bus0.in_reg_write = c_rw; assign bus1.in_reg_write = c_rw;
    assign bus0.in_wb_sel = c_sel;   assign bus1.in_wb_sel = c_sel;
    assign bus0.in_rd = c_rd;        assign bus1.in_rd = c_rd;
    assign bus0.in_alu_result = c_alu; assign bus1.in_alu_result = c_alu;
    assign bus0.in_mem_data = c_mem; assign bus1.in_mem_data = c_mem;
    assign bus0.in_pc_plus4 = c_pc;  assign bus1.in_pc_plus4 = c_pc;
    assign bus0.flush = c_flush;     assign bus1.flush = c_flush;
    assign bus0.out_ready = c_ordy;  assign bus1.out_ready = c_ordy;

    // Reference model: each build is a FIFO of accepted entries, capacity 2 or 1.
    logic [EW-1:0] exp_q[2][$];
    int unsigned   stall_m[2];
    bit            acc_last[2];
    bit            chk_en = 1'b0;
    int            n_vec = 0;
    int            n_miss = 0;

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic sample(input int d, output logic ov, output logic ir, output logic orw,
                          output logic [AW-1:0] rd, output logic [DW-1:0] dat, output logic [63:0] sc);
        if (d == 0) begin
            ov = bus0.out_valid; ir = bus0.in_ready; orw = bus0.out_reg_write;
            rd = bus0.out_rd; dat = bus0.out_wb_data; sc = 64'(stall0);
        end else begin
            ov = bus1.out_valid; ir = bus1.in_ready; orw = bus1.out_reg_write;
            rd = bus1.out_rd; dat = bus1.out_wb_data; sc = 64'(stall1);
        end
    endtask

    function automatic logic [EW-1:0] model_entry();
        logic [DW-1:0] v;
        logic          w;
        if (c_sel == 2'b01)      v = c_mem;
        else if (c_sel == 2'b10) v = c_pc;
        else                     v = c_alu;
        w = (c_rw || c_sel == 2'b10) && (c_rd != '0);
        return {w, c_rd, v};
    endfunction

    task automatic monitor(input int d);
        logic ov, ir, orw;
        logic [AW-1:0] rd;
        logic [DW-1:0] dat;
        logic [63:0] sc;
        logic [EW-1:0] e;
        int sz;
        bit exp_ir;
        int unsigned sat;
        sample(d, ov, ir, orw, rd, dat, sc);
        sat = (d == 0) ? 32'd65535 : 32'd15;
        chk("stall_cnt", d, sc, 64'(stall_m[d]));
        sz = exp_q[d].size();
        exp_ir = (d == 0) ? (sz < 2) : (sz == 0 || c_ordy);
        chk("out_valid", d, 64'(ov), 64'(sz > 0));
        chk("in_ready", d, 64'(ir), 64'(exp_ir));
        if (sz > 0) begin
            e = exp_q[d][0];
            chk("out_rd", d, 64'(rd), 64'(e[DW +: AW]));
            chk("out_wb_data", d, 64'(dat), 64'(e[DW-1:0]));
            chk("out_reg_write", d, 64'(orw), 64'(e[EW-1]));
            if (c_ordy) void'(exp_q[d].pop_front());
        end else begin
            chk("out_reg_write_idle", d, 64'(orw), 64'd0);
        end
        if (sz > 0 && !c_ordy && stall_m[d] < sat) stall_m[d]++;
        acc_last[d] = 1'b0;
        if (c_flush) begin
            exp_q[d].delete();
        end else if (c_valid && exp_ir) begin
            exp_q[d].push_back(model_entry());
            acc_last[d] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) monitor(d);
        end
    end

    task automatic drive(input logic v, input logic rw, input logic [1:0] sel, input logic [AW-1:0] rd,
                         input logic [DW-1:0] alu, input logic [DW-1:0] mem, input logic [DW-1:0] pc,
                         input logic fl);
        c_valid = v; c_rw = rw; c_sel = sel; c_rd = rd;
        c_alu = alu; c_mem = mem; c_pc = pc; c_flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_check();
        logic ov, ir, orw;
        logic [AW-1:0] rd;
        logic [DW-1:0] dat;
        logic [63:0] sc;
        for (int d = 0; d < 2; d++) begin
            sample(d, ov, ir, orw, rd, dat, sc);
            chk("rst_out_valid", d, 64'(ov), 64'd0);
            chk("rst_in_ready", d, 64'(ir), 64'd1);
            chk("rst_out_reg_write", d, 64'(orw), 64'd0);
            chk("rst_out_rd", d, 64'(rd), 64'd0);
            chk("rst_out_wb_data", d, 64'(dat), 64'd0);
            chk("rst_stall_cnt", d, sc, 64'd0);
            exp_q[d].delete();
            stall_m[d] = 0;
        end
    endtask

    // Called just after a rising edge; the whole pulse ends before the next falling edge.
    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1 reset_check();
        #1 rst = 1'b0;
    endtask

    initial begin
        idle();
        step(3);
        reset_check();
        rst = 1'b0;
        chk_en = 1'b1;

        c_ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 2'b00, AW'(i + 1), 32'h10 + DW'(i), $urandom, $urandom, 1'b0);
            step(1);
        end
        idle();
        step(2);

        drive(1'b1, 1'b0, 2'b10, 5'd31, $urandom, $urandom, 32'h0000_0044, 1'b0); step(1);
        drive(1'b1, 1'b1, 2'b00, 5'd0, 32'hdead_beef, $urandom, $urandom, 1'b0);   step(1);
        drive(1'b1, 1'b1, 2'b01, 5'd7, $urandom, 32'h1234_5678, $urandom, 1'b0);   step(1);
        drive(1'b1, 1'b1, 2'b11, 5'd9, 32'h0000_a5a5, $urandom, $urandom, 1'b0);   step(1);
        drive(1'b1, 1'b0, 2'b01, 5'd3, $urandom, 32'h5555_0000, $urandom, 1'b0);   step(1);
        idle();
        step(2);

        c_ordy = 1'b0;
        drive(1'b1, 1'b1, 2'b00, 5'd10, 32'h0000_00aa, $urandom, $urandom, 1'b0); step(1);
        drive(1'b1, 1'b1, 2'b00, 5'd11, 32'h0000_00bb, $urandom, $urandom, 1'b0); step(1);
        drive(1'b1, 1'b1, 2'b00, 5'd12, 32'h0000_00cc, $urandom, $urandom, 1'b0); step(2);
        chk("bp_stall_cnt", 0, 64'(stall0), 64'd3);
        c_ordy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (acc_last[0]) break;
        end
        idle();
        step(4);

        c_ordy = 1'b0;
        drive(1'b1, 1'b1, 2'b00, 5'd13, 32'h0000_00ee, $urandom, $urandom, 1'b0); step(1);
        drive(1'b1, 1'b1, 2'b00, 5'd14, 32'h0000_00ff, $urandom, $urandom, 1'b0); step(1);
        drive(1'b1, 1'b1, 2'b00, 5'd15, 32'h0000_00dd, $urandom, $urandom, 1'b1); step(1);
        idle();
        step(3);
        c_ordy = 1'b1;
        step(2);

        repeat (600) begin
            drive(1'b1 && ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  AW'($urandom_range(0, 31)), $urandom, $urandom, $urandom, $urandom_range(0, 31) == 0);
            c_ordy = ($urandom_range(0, 9) < 6);
            step(1);
        end
        idle();
        c_ordy = 1'b1;
        step(3);

        c_ordy = 1'b0;
        drive(1'b1, 1'b1, 2'b00, 5'd20, 32'h0000_1111, $urandom, $urandom, 1'b0); step(1);
        idle();
        step(5);
        pulse_reset();
        step(2);

        drive(1'b1, 1'b1, 2'b00, 5'd21, 32'h0000_2222, $urandom, $urandom, 1'b0); step(1);
        idle();
        step(20);
        chk("sat_stall_cnt", 1, 64'(stall1), 64'hf);
        c_ordy = 1'b1;
        step(3);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
